ddr_tx_sequencer: RTL and testbench

Frame-level controller for the HDR-DDR transmit serializer. It accepts a transfer request from the host/CCC engine and sequences the serializer through a complete frame: command word, data words, CRC token and CRC value. It drives the serializer's enable, mode and special-data inputs, and advances on each mode-done pulse. It sits between the DDR/CCC control FSM and the serializer, and pops the register-file TX buffer one byte at a time.

---
 rtl/ddr_tx_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_ddr_tx_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_tx_sequencer.sv
// HDR-DDR transmit frame sequencer.
// Walks the serializer through one frame: command word (preamble, R/W,
// command byte, address, parity), payload words (two bytes each), then
// the CRC token and CRC value. Every serializer output is registered.
//
// Serializer handshake: o_tx_mode/o_special_data are the offered mode.
// They stay stable while o_tx_en is high until i_tx_mode_done is sampled
// high. That sample completes the mode, and the next mode appears on the
// following edge. A done pulse is ignored while idle, and it is also
// ignored in the same cycle as an abort or a watchdog timeout.
module ddr_tx_sequencer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_start,
  input  logic       i_rnw,
  input  logic [7:0] i_cmd_code,
  input  logic [6:0] i_target_addr,
  input  logic [7:0] i_byte_count,
  input  logic       i_abort,
  input  logic       i_tx_mode_done,
  output logic       o_tx_en,
  output logic [3:0] o_tx_mode,
  output logic [7:0] o_special_data,
  output logic       o_regf_rd_en,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_rx_handoff,
  output logic       o_error
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0] MODE_IDLE        = 4'b0000;
  localparam logic [3:0] MODE_SPECIAL_PRE = 4'b0001;
  localparam logic [3:0] MODE_ONE_PRE     = 4'b0010;
  localparam logic [3:0] MODE_ZERO_PRE    = 4'b0011;
  localparam logic [3:0] MODE_BYTE        = 4'b0100;
  localparam logic [3:0] MODE_PARITY      = 4'b0101;
  localparam logic [3:0] MODE_CRC_VAL     = 4'b0110;
  localparam logic [3:0] MODE_CRC_TOKEN   = 4'b0111;
  localparam logic [3:0] MODE_ADDR        = 4'b1010;
  localparam logic [3:0] MODE_ZEROS       = 4'b1100;
  localparam logic [3:0] MODE_CCC_VAL     = 4'b1101;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_PRE,
    S_CMD_RW,
    S_CMD_CODE,
    S_CMD_ADDR,
    S_CMD_PAR,
    S_D_PRE1,
    S_D_PRE0,
    S_D_HI,
    S_D_LO,
    S_D_PAR,
    S_CRC_TOK,
    S_CRC_V
  } state_t;

  state_t          state_q, state_d;
  logic            rnw_q;
  logic [7:0]      cmd_q;
  logic [6:0]      addr_q;
  logic [7:0]      rem_q, rem_d;
  logic [WD_W-1:0] wd_q;
  logic            timeout;
  logic            rd_d, done_d, rx_d, err_d;
  logic [3:0]      mode_d;
  logic [7:0]      special_d;

  // Next-state, byte accounting and completion pulses; abort beats timeout beats mode-done.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    rx_d    = 1'b0;
    err_d   = 1'b0;
    timeout = (state_q != S_IDLE) && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    if (state_q == S_IDLE) begin
      if (i_start) begin
        state_d = S_CMD_PRE;
        rem_d   = i_byte_count;
      end
    end else if (i_abort) begin
      state_d = S_IDLE;
    end else if (timeout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else if (i_tx_mode_done) begin
      case (state_q)
        S_CMD_PRE:  state_d = S_CMD_RW;
        S_CMD_RW:   state_d = S_CMD_CODE;
        S_CMD_CODE: state_d = S_CMD_ADDR;
        S_CMD_ADDR: state_d = S_CMD_PAR;
        S_CMD_PAR: begin
          if (rnw_q) begin
            state_d = S_IDLE;
            rx_d    = 1'b1;
          end else if (rem_q == 8'd0) begin
            state_d = S_CRC_TOK;
          end else begin
            state_d = S_D_PRE1;
          end
        end
        S_D_PRE1:   state_d = S_D_PRE0;
        S_D_PRE0:   state_d = S_D_HI;
        S_D_HI: begin
          state_d = S_D_LO;
          rd_d    = 1'b1;
          rem_d   = (rem_q != 8'd0) ? rem_q - 8'd1 : 8'd0;
        end
        S_D_LO: begin
          state_d = S_D_PAR;
          // A zero-padded low byte does not consume buffer data.
          if (o_tx_mode == MODE_BYTE) begin
            rd_d  = 1'b1;
            rem_d = (rem_q != 8'd0) ? rem_q - 8'd1 : 8'd0;
          end
        end
        S_D_PAR:    state_d = (rem_q != 8'd0) ? S_D_PRE1 : S_CRC_TOK;
        S_CRC_TOK:  state_d = S_CRC_V;
        S_CRC_V: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Mode and special byte offered in the state being entered.
  always_comb begin
    mode_d    = MODE_IDLE;
    special_d = 8'h00;
    case (state_d)
      S_CMD_PRE:  mode_d = MODE_SPECIAL_PRE;
      S_CMD_RW:   mode_d = rnw_q ? MODE_ONE_PRE : MODE_ZERO_PRE;
      S_CMD_CODE: begin
        mode_d    = MODE_CCC_VAL;
        special_d = cmd_q;
      end
      S_CMD_ADDR: begin
        mode_d    = MODE_ADDR;
        special_d = {1'b0, addr_q};
      end
      S_CMD_PAR:  mode_d = MODE_PARITY;
      S_D_PRE1:   mode_d = MODE_ONE_PRE;
      S_D_PRE0:   mode_d = MODE_ZERO_PRE;
      S_D_HI:     mode_d = MODE_BYTE;
      S_D_LO:     mode_d = (rem_d != 8'd0) ? MODE_BYTE : MODE_ZEROS;
      S_D_PAR:    mode_d = MODE_PARITY;
      S_CRC_TOK:  mode_d = MODE_CRC_TOKEN;
      S_CRC_V:    mode_d = MODE_CRC_VAL;
      default:    mode_d = MODE_IDLE;
    endcase
  end

  // State, request latch, remaining count and watchdog registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q <= S_IDLE;
      rnw_q   <= 1'b0;
      cmd_q   <= 8'h00;
      addr_q  <= 7'h00;
      rem_q   <= 8'h00;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (state_q == S_IDLE && i_start) begin
        rnw_q  <= i_rnw;
        cmd_q  <= i_cmd_code;
        addr_q <= i_target_addr;
      end
      if (state_q == S_IDLE || state_d != state_q) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + WD_W'(1);
      end
    end
  end

  // Registered serializer controls and status pulses.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      o_tx_en        <= 1'b0;
      o_tx_mode      <= MODE_IDLE;
      o_special_data <= 8'h00;
      o_regf_rd_en   <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_rx_handoff   <= 1'b0;
      o_error        <= 1'b0;
    end else begin
      o_tx_en        <= (state_d != S_IDLE);
      o_tx_mode      <= mode_d;
      o_special_data <= special_d;
      o_regf_rd_en   <= rd_d;
      o_busy         <= (state_d != S_IDLE);
      o_done         <= done_d;
      o_rx_handoff   <= rx_d;
      o_error        <= err_d;
    end
  end

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Bench for ddr_tx_sequencer: directed frames from the test plan, random
// frames against a frame-level mode-list model, watchdog, abort and reset.
module tb_ddr_tx_sequencer;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic       i_rnw;
  logic [7:0] i_cmd_code;
  logic [6:0] i_target_addr;
  logic [7:0] i_byte_count;
  logic       i_abort;
  logic       i_tx_mode_done;
  logic       o_tx_en;
  logic [3:0] o_tx_mode;
  logic [7:0] o_special_data;
  logic       o_regf_rd_en;
  logic       o_busy;
  logic       o_done;
  logic       o_rx_handoff;
  logic       o_error;

  int n_checks = 0;
  int n_fail   = 0;

  ddr_tx_sequencer #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .i_sys_clk      (clk),
    .i_sys_rst      (rst_n),
    .i_start        (i_start),
    .i_rnw          (i_rnw),
    .i_cmd_code     (i_cmd_code),
    .i_target_addr  (i_target_addr),
    .i_byte_count   (i_byte_count),
    .i_abort        (i_abort),
    .i_tx_mode_done (i_tx_mode_done),
    .o_tx_en        (o_tx_en),
    .o_tx_mode      (o_tx_mode),
    .o_special_data (o_special_data),
    .o_regf_rd_en   (o_regf_rd_en),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_rx_handoff   (o_rx_handoff),
    .o_error        (o_error)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_tx_en"}, o_tx_en, 0);
    check({tag, "_mode"}, o_tx_mode, 0);
    check({tag, "_special"}, o_special_data, 0);
    check({tag, "_rd_en"}, o_regf_rd_en, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_rx_handoff"}, o_rx_handoff, 0);
    check({tag, "_error"}, o_error, 0);
  endtask

  // Runs one frame starting at the current negedge. fixed_dly < 0 picks a
  // random serializer latency per mode. Returns at the negedge where the
  // completion pulse is visible.
  task automatic run_frame(input logic rnw, input logic [7:0] cmd, input logic [6:0] addr,
                           input logic [7:0] cnt, input int fixed_dly);
    logic [3:0] em[$];
    logic [7:0] es[$];
    logic [3:0] exp_m;
    logic [7:0] exp_s;
    logic [3:0] cur;
    int words, rd, hold, dly, cyc;
    em.push_back(4'h1); es.push_back(8'h00);
    em.push_back(rnw ? 4'h2 : 4'h3); es.push_back(8'h00);
    em.push_back(4'hD); es.push_back(cmd);
    em.push_back(4'hA); es.push_back({1'b0, addr});
    em.push_back(4'h5); es.push_back(8'h00);
    if (!rnw) begin
      words = (int'(cnt) + 1) / 2;
      for (int w = 0; w < words; w++) begin
        em.push_back(4'h2); es.push_back(8'h00);
        em.push_back(4'h3); es.push_back(8'h00);
        em.push_back(4'h4); es.push_back(8'h00);
        em.push_back((2 * w + 1 < int'(cnt)) ? 4'h4 : 4'hC); es.push_back(8'h00);
        em.push_back(4'h5); es.push_back(8'h00);
      end
      em.push_back(4'h7); es.push_back(8'h00);
      em.push_back(4'h6); es.push_back(8'h00);
    end
    i_rnw = rnw; i_cmd_code = cmd; i_target_addr = addr; i_byte_count = cnt;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_rnw = 1'($urandom); i_cmd_code = 8'($urandom);
    i_target_addr = 7'($urandom); i_byte_count = 8'($urandom);
    check("start_busy", o_busy, 1);
    check("start_mode", o_tx_mode, 4'h1);
    rd = 0; hold = 0; dly = 0; cyc = 0; cur = 4'h0;
    while (o_busy && cyc < 3000) begin
      if (!o_tx_en) check("tx_en_held", o_tx_en, 1);
      if (o_regf_rd_en) rd++;
      if (hold == 0) begin
        exp_m = (em.size() > 0) ? em.pop_front() : 4'hF;
        exp_s = (es.size() > 0) ? es.pop_front() : 8'h00;
        check("mode_seq", o_tx_mode, exp_m);
        if (exp_m == 4'hD || exp_m == 4'hA) check("special_data", o_special_data, exp_s);
        cur = o_tx_mode;
        dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 5));
      end else if (o_tx_mode !== cur) begin
        check("mode_hold", o_tx_mode, cur);
      end
      if (hold == dly) begin
        i_tx_mode_done = 1'b1;
        hold = 0;
      end else begin
        i_tx_mode_done = 1'b0;
        hold++;
      end
      @(negedge clk);
      cyc++;
    end
    i_tx_mode_done = 1'b0;
    check("frame_in_budget", o_busy, 0);
    check("modes_left", em.size(), 0);
    check("rd_en_pulses", rd, rnw ? 0 : cnt);
    check("done_pulse", o_done, !rnw);
    check("rx_handoff_pulse", o_rx_handoff, rnw);
    check("no_error", o_error, 0);
    check("tx_en_drop", o_tx_en, 0);
    check("idle_mode", o_tx_mode, 0);
  endtask

  task automatic idle_check;
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
    check("handoff_one_cycle", o_rx_handoff, 0);
    check("idle_busy", o_busy, 0);
  endtask

  initial begin
    int n;
    int hold;
    logic found;
    rst_n = 1'b0;
    i_start = 1'b0; i_rnw = 1'b0; i_cmd_code = 8'h00; i_target_addr = 7'h00;
    i_byte_count = 8'h00; i_abort = 1'b0; i_tx_mode_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_reset("post_reset");

    // Directed frames
    run_frame(1'b0, 8'h0A, 7'h52, 8'd2, 4); idle_check();
    run_frame(1'b0, 8'h33, 7'h11, 8'd3, 4); idle_check();
    run_frame(1'b1, 8'h8F, 7'h2C, 8'd5, 4); idle_check();
    check("read_no_rd_en", o_regf_rd_en, 0);
    run_frame(1'b0, 8'h44, 7'h7F, 8'd0, 4); idle_check();

    // Back-to-back: second request in the first IDLE cycle
    run_frame(1'b0, 8'hA5, 7'h05, 8'd1, 1);
    run_frame(1'b1, 8'h5A, 7'h3A, 8'd0, 0); idle_check();

    // Random frames
    for (int k = 0; k < 10; k++) begin
      run_frame(1'($urandom), 8'($urandom), 7'($urandom), 8'($urandom_range(0, 7)), -1);
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    // Watchdog: serializer never acknowledges
    i_rnw = 1'b0; i_byte_count = 8'd2; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_busy_cycles", n, TIMEOUT);
    check("timeout_error", o_error, 1);
    check("timeout_no_done", o_done, 0);
    check("timeout_tx_en", o_tx_en, 0);
    @(negedge clk);
    check("error_one_cycle", o_error, 0);
    run_frame(1'b0, 8'h12, 7'h34, 8'd2, 2); idle_check();

    // Abort during D_HI
    i_rnw = 1'b0; i_byte_count = 8'd4; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    hold = 0; found = 1'b0; n = 0;
    while (!found && n < 200) begin
      if (o_tx_mode == 4'h4) begin
        found = 1'b1;
        i_tx_mode_done = 1'b1;
        i_abort = 1'b1;
      end else begin
        i_tx_mode_done = (hold == 2);
        hold = (hold == 2) ? 0 : hold + 1;
        @(negedge clk);
        n++;
      end
    end
    check("abort_reached_d_hi", found, 1);
    @(negedge clk);
    i_abort = 1'b0; i_tx_mode_done = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_tx_en", o_tx_en, 0);
    check("abort_no_done", o_done, 0);
    check("abort_no_error", o_error, 0);
    check("abort_no_rd_en", o_regf_rd_en, 0);
    idle_check();

    // Asynchronous reset mid-frame
    i_rnw = 1'b0; i_byte_count = 8'd3; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_tx_mode_done = 1'b1;
    repeat (3) @(negedge clk);
    i_tx_mode_done = 1'b0;
    check("pre_reset_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_reset("after_async_reset");
    run_frame(1'b0, 8'h0A, 7'h52, 8'd2, 3); idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
